// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage and the downstream 4-bit-select ALU:
// ALU select codes, ALUOp encodings, R-type funct codes and the select decoder.
package id_ex_stage_pkg;

    // ALU select codes (the ALU decodes these same constants)
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;
    localparam logic [3:0] SEL_BAD = 4'b1111;

    // ALUOp encodings produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    // R-type funct codes understood by the ALU
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic [3:0] sel;
        logic       illegal;
    } alu_ctl_t;

    // Translate ALUOp/funct into the ALU select; unknown R-type functs map to
    // SEL_BAD (ALU outputs 0) and raise the illegal flag.
    function automatic alu_ctl_t alu_decode(input logic [1:0] op, input logic [5:0] funct);
        alu_ctl_t c;
        c.sel     = SEL_ADD;
        c.illegal = 1'b0;
        case (op)
            ALUOP_ADD: c.sel = SEL_ADD;
            ALUOP_SUB: c.sel = SEL_SUB;
            ALUOP_AND: c.sel = SEL_AND;
            default: begin
                case (funct)
                    FUNCT_ADD: c.sel = SEL_ADD;
                    FUNCT_SUB: c.sel = SEL_SUB;
                    FUNCT_AND: c.sel = SEL_AND;
                    FUNCT_OR:  c.sel = SEL_OR;
                    FUNCT_NOR: c.sel = SEL_NOR;
                    FUNCT_SLT: c.sel = SEL_SLT;
                    default: begin
                        c.sel     = SEL_BAD;
                        c.illegal = 1'b1;
                    end
                endcase
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one EX source operand.
// With FORWARDING_EN defined, EX/MEM beats MEM/WB beats the registered value,
// and register 0 is never forwarded. Without it, the registered value passes
// straight through and the forwarding inputs are ignored.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_val,
    input  logic          exmem_we,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_val,
    input  logic          memwb_we,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_val,
    output logic [DW-1:0] val
);

`ifdef FORWARDING_EN
    logic src_nz;
    assign src_nz = (src != '0);

    // Priority select: the younger EX/MEM result shadows the older MEM/WB one
    always_comb begin
        val = reg_val;
        if (exmem_we && (exmem_rd == src) && src_nz)
            val = exmem_val;
        else if (memwb_we && (memwb_rd == src) && src_nz)
            val = memwb_val;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{src, exmem_we, exmem_rd, exmem_val, memwb_we, memwb_rd, memwb_val};

    // No forwarding: the registered operand is used as-is
    always_comb begin
        val = reg_val;
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage feeding the 4-bit-select ALU.
// Registers decoded operands/control, extends the immediate, decodes the ALU
// select, and presents ALU operands to EX one cycle later. Supports stall
// (hold) and flush (bubble). Optional operand forwarding under FORWARDING_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [15:0]   id_imm,
    input  logic          id_ext_zero,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_branch,
    input  logic          fwd_exmem_we,
    input  logic          fwd_memwb_we,
    input  logic [RW-1:0] fwd_exmem_rd,
    input  logic [RW-1:0] fwd_memwb_rd,
    input  logic [DW-1:0] fwd_exmem_val,
    input  logic [DW-1:0] fwd_memwb_val,
    output logic          ex_valid,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [3:0]    ex_sel,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_branch,
    output logic          ex_illegal
);

    // Zero- or sign-extend the 16-bit immediate to the datapath width
    function automatic logic [DW-1:0] extend_imm(input logic [15:0] imm, input logic zero);
        logic signed [15:0] simm;
        simm = imm;
        if (zero)
            return {{(DW-16){1'b0}}, imm};
        else
            return {{(DW-16){simm[15]}}, simm};
    endfunction

    alu_ctl_t      dec_p0;
    logic [DW-1:0] imm_p0;
    logic [RW-1:0] dest_p0;

    assign dec_p0  = alu_decode(id_alu_op, id_funct);
    assign imm_p0  = extend_imm(id_imm, id_ext_zero);
    assign dest_p0 = id_reg_dst ? id_rd : id_rt;

    // ---- ID / EX register boundary ----
    logic          vld_p1;
    logic [DW-1:0] rs_val_p1;
    logic [DW-1:0] rt_val_p1;
    logic [RW-1:0] rs_p1;
    logic [RW-1:0] rt_p1;
    logic [RW-1:0] dest_p1;
    logic [DW-1:0] imm_p1;
    logic [3:0]    sel_p1;
    logic          illegal_p1;
    logic          alu_src_p1;
    logic          reg_write_p1;
    logic          mem_read_p1;
    logic          mem_write_p1;
    logic          mem_to_reg_p1;
    logic          branch_p1;

    // Stage register: reset/flush load a zeroed bubble, stall holds, else capture ID
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1        <= 1'b0;
            rs_val_p1     <= '0;
            rt_val_p1     <= '0;
            rs_p1         <= '0;
            rt_p1         <= '0;
            dest_p1       <= '0;
            imm_p1        <= '0;
            sel_p1        <= '0;
            illegal_p1    <= 1'b0;
            alu_src_p1    <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            branch_p1     <= 1'b0;
        end else if (!stall) begin
            vld_p1        <= id_valid;
            rs_val_p1     <= id_rs_val;
            rt_val_p1     <= id_rt_val;
            rs_p1         <= id_rs;
            rt_p1         <= id_rt;
            dest_p1       <= dest_p0;
            imm_p1        <= imm_p0;
            sel_p1        <= id_valid ? dec_p0.sel : SEL_AND;
            illegal_p1    <= id_valid & dec_p0.illegal;
            alu_src_p1    <= id_valid & id_alu_src;
            reg_write_p1  <= id_valid & id_reg_write;
            mem_read_p1   <= id_valid & id_mem_read;
            mem_write_p1  <= id_valid & id_mem_write;
            mem_to_reg_p1 <= id_valid & id_mem_to_reg;
            branch_p1     <= id_valid & id_branch;
        end
    end

    // ---- EX operand selection (combinational from stage registers) ----
    logic [DW-1:0] rs_f_p1;
    logic [DW-1:0] rt_f_p1;

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src       (rs_p1),
        .reg_val   (rs_val_p1),
        .exmem_we  (fwd_exmem_we),
        .exmem_rd  (fwd_exmem_rd),
        .exmem_val (fwd_exmem_val),
        .memwb_we  (fwd_memwb_we),
        .memwb_rd  (fwd_memwb_rd),
        .memwb_val (fwd_memwb_val),
        .val       (rs_f_p1)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src       (rt_p1),
        .reg_val   (rt_val_p1),
        .exmem_we  (fwd_exmem_we),
        .exmem_rd  (fwd_exmem_rd),
        .exmem_val (fwd_exmem_val),
        .memwb_we  (fwd_memwb_we),
        .memwb_rd  (fwd_memwb_rd),
        .memwb_val (fwd_memwb_val),
        .val       (rt_f_p1)
    );

    assign ex_a          = rs_f_p1;
    assign ex_b          = alu_src_p1 ? imm_p1 : rt_f_p1;
    assign ex_store_data = rt_f_p1;
    assign ex_valid      = vld_p1;
    assign ex_sel        = sel_p1;
    assign ex_illegal    = illegal_p1;
    assign ex_dest       = dest_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_read   = mem_read_p1;
    assign ex_mem_write  = mem_write_p1;
    assign ex_mem_to_reg = mem_to_reg_p1;
    assign ex_branch     = branch_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, select decode, immediate extension,
// stall/flush and operand forwarding (expectations follow FORWARDING_EN).
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst, stall, flush, id_valid;
    logic [DW-1:0] id_rs_val, id_rt_val;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [15:0]   id_imm;
    logic          id_ext_zero;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;
    logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic          fwd_exmem_we, fwd_memwb_we;
    logic [RW-1:0] fwd_exmem_rd, fwd_memwb_rd;
    logic [DW-1:0] fwd_exmem_val, fwd_memwb_val;
    logic          ex_valid;
    logic [DW-1:0] ex_a, ex_b, ex_store_data;
    logic [3:0]    ex_sel;
    logic [RW-1:0] ex_dest;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_ext_zero(id_ext_zero),
        .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .fwd_exmem_we(fwd_exmem_we), .fwd_memwb_we(fwd_memwb_we),
        .fwd_exmem_rd(fwd_exmem_rd), .fwd_memwb_rd(fwd_memwb_rd),
        .fwd_exmem_val(fwd_exmem_val), .fwd_memwb_val(fwd_memwb_val),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_sel(ex_sel),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_val = '0; id_rt_val = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_imm = '0; id_ext_zero = 0; id_alu_op = 2'b00; id_funct = '0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
        fwd_exmem_we = 0; fwd_memwb_we = 0; fwd_exmem_rd = '0; fwd_memwb_rd = '0;
        fwd_exmem_val = '0; fwd_memwb_val = '0;
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        rst = 1; idle_inputs();
        step(); step();
        ctl = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal};
        n_tests++;
        if (ctl !== 7'b0 || ex_sel !== 4'b0000 || ex_a !== 32'h0 || ex_dest !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ctl=%b sel=%b a=%h dest=%0d expected all zero", ctl, ex_sel, ex_a, ex_dest);
        end
        rst = 0;
        // R-type add into EX
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100000;
        id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd6; id_rs_val = 32'd11; id_rt_val = 32'd22;
        id_reg_dst = 1; id_reg_write = 1;
        step();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_sel !== 4'b0010 || ex_a !== 32'd11 || ex_b !== 32'd22 || ex_dest !== 5'd6 || ex_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL load_add: got v=%b sel=%b a=%0d b=%0d dest=%0d rw=%b expected v=1 sel=0010 a=11 b=22 dest=6 rw=1",
                     ex_valid, ex_sel, ex_a, ex_b, ex_dest, ex_reg_write);
        end
        // Reset mid-stream with the add still on the ID inputs
        rst = 1;
        step();
        rst = 0;
        ctl = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal};
        n_tests++;
        if (ctl !== 7'b0 || ex_sel !== 4'b0000 || ex_a !== 32'h0 || ex_dest !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_midstream: got ctl=%b sel=%b a=%h dest=%0d expected all zero", ctl, ex_sel, ex_a, ex_dest);
        end
        idle_inputs();
    endtask

    task automatic test_decode();
        idle_inputs();
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b101010;
        step();
        n_tests++;
        if (ex_sel !== 4'b0111 || ex_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_slt: got sel=%b ill=%b expected sel=0111 ill=0", ex_sel, ex_illegal);
        end
        id_funct = 6'b000000;
        step();
        n_tests++;
        if (ex_sel !== 4'b1111 || ex_illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_illegal: got sel=%b ill=%b expected sel=1111 ill=1", ex_sel, ex_illegal);
        end
        id_alu_op = 2'b01;
        step();
        n_tests++;
        if (ex_sel !== 4'b0110 || ex_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_sub_op: got sel=%b ill=%b expected sel=0110 ill=0", ex_sel, ex_illegal);
        end
        id_alu_op = 2'b10; id_funct = 6'b100111;
        step();
        n_tests++;
        if (ex_sel !== 4'b1100) begin
            n_fail++;
            $display("FAIL decode_nor: got sel=%b expected sel=1100", ex_sel);
        end
        id_funct = 6'b100101;
        step();
        n_tests++;
        if (ex_sel !== 4'b0001) begin
            n_fail++;
            $display("FAIL decode_or: got sel=%b expected sel=0001", ex_sel);
        end
        id_alu_op = 2'b11;
        step();
        n_tests++;
        if (ex_sel !== 4'b0000 || ex_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_and_op: got sel=%b ill=%b expected sel=0000 ill=0", ex_sel, ex_illegal);
        end
        // Invalid ID slot with a bad funct loads as a clean bubble
        id_valid = 0; id_alu_op = 2'b10; id_funct = 6'b000000; id_reg_write = 1;
        step();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_illegal !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_bubble: got v=%b ill=%b rw=%b expected 0 0 0", ex_valid, ex_illegal, ex_reg_write);
        end
        idle_inputs();
    endtask

    task automatic test_immediate();
        idle_inputs();
        id_valid = 1; id_imm = 16'h8001; id_alu_src = 1; id_ext_zero = 0; id_rt_val = 32'hCAFE0001;
        step();
        n_tests++;
        if (ex_b !== 32'hFFFF8001 || ex_store_data !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL imm_sign: got b=%h sd=%h expected b=ffff8001 sd=cafe0001", ex_b, ex_store_data);
        end
        id_ext_zero = 1;
        step();
        n_tests++;
        if (ex_b !== 32'h00008001) begin
            n_fail++;
            $display("FAIL imm_zero: got b=%h expected b=00008001", ex_b);
        end
        id_imm = 16'h7FFF; id_ext_zero = 0;
        step();
        n_tests++;
        if (ex_b !== 32'h00007FFF) begin
            n_fail++;
            $display("FAIL imm_sign_pos: got b=%h expected b=00007fff", ex_b);
        end
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        id_valid = 1; id_alu_op = 2'b01; id_rs_val = 32'h1234; id_rd = 5'd9; id_reg_dst = 1; id_reg_write = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs_val = 32'hA0 + i; id_alu_op = 2'b00; id_rd = 5'd1 + 5'(i); id_valid = i[0];
            step();
            n_tests++;
            if (ex_a !== 32'h1234 || ex_sel !== 4'b0110 || ex_dest !== 5'd9 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got a=%h sel=%b dest=%0d v=%b rw=%b expected a=1234 sel=0110 dest=9 v=1 rw=1",
                         i, ex_a, ex_sel, ex_dest, ex_valid, ex_reg_write);
            end
        end
        id_valid = 1; id_reg_write = 1;
        flush = 1;
        step();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_sel !== 4'b0000 || ex_a !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_over_stall: got v=%b rw=%b sel=%b a=%h expected 0 0 0000 0", ex_valid, ex_reg_write, ex_sel, ex_a);
        end
        idle_inputs();
    endtask

    task automatic test_forwarding();
        logic [DW-1:0] exp;
        idle_inputs();
        id_valid = 1; id_rs = 5'd5; id_rs_val = 32'd1; id_rt = 5'd5; id_rt_val = 32'd1;
        step();
        idle_inputs();
        stall = 1;
        fwd_exmem_we = 1; fwd_exmem_rd = 5'd5; fwd_exmem_val = 32'd7;
        fwd_memwb_we = 1; fwd_memwb_rd = 5'd5; fwd_memwb_val = 32'd9;
        #1;
`ifdef FORWARDING_EN
        exp = 32'd7;
`else
        exp = 32'd1;
`endif
        n_tests++;
        if (ex_a !== exp || ex_store_data !== exp) begin
            n_fail++;
            $display("FAIL fwd_both: got a=%0d sd=%0d expected %0d", ex_a, ex_store_data, exp);
        end
        fwd_exmem_rd = 5'd6;
        #1;
`ifdef FORWARDING_EN
        exp = 32'd9;
`else
        exp = 32'd1;
`endif
        n_tests++;
        if (ex_a !== exp) begin
            n_fail++;
            $display("FAIL fwd_memwb_only: got a=%0d expected %0d", ex_a, exp);
        end
        stall = 0;
        id_valid = 1; id_rs = 5'd0; id_rs_val = 32'd1;
        fwd_exmem_rd = 5'd0; fwd_memwb_rd = 5'd0;
        step();
        n_tests++;
        if (ex_a !== 32'd1) begin
            n_fail++;
            $display("FAIL fwd_r0: got a=%0d expected 1", ex_a);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_decode();
        test_immediate();
        test_stall_flush();
        test_forwarding();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 4-bit-select ALU.
- Captures decoded operands and control from ID and sign/zero-extends the immediate.
- Translates ALUOp/funct into the ALU select code.
- Presents the ALU A/B operands and control to EX one cycle later.
- Supports pipeline hold (stall) and bubble insertion (flush).
- Optional EX/MEM and MEM/WB operand forwarding.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_val, id_rt_val  in  DW  register-file read data.
- id_rs, id_rt, id_rd  in  RW  register addresses.
- id_imm  in  16  instruction immediate.
- id_ext_zero  in  1  1 = zero-extend immediate, 0 = sign-extend.
- id_alu_op  in  2  00 add, 01 sub, 10 R-type via funct, 11 and.
- id_funct  in  6  R-type funct.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control.
- fwd_exmem_we, fwd_memwb_we  in  1  later-stage write enables.
- fwd_exmem_rd, fwd_memwb_rd  in  RW  later-stage destinations.
- fwd_exmem_val, fwd_memwb_val  in  DW  later-stage results.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_a, ex_b  out  DW  ALU operands.
- ex_sel  out  4  ALU select.
- ex_store_data  out  DW  store data (rt after forwarding).
- ex_dest  out  RW  destination: rd if reg_dst, else rt.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1  registered control.
- ex_illegal  out  1  unsupported funct under ALUOp 10.

Behaviour:
- Update priority per rising edge: rst > flush > stall > load.
- rst and flush: every registered field cleared to 0. So ex_valid=0, all control=0, ex_sel=0000, ex_dest=0, stored operands/imm/addresses=0.
- stall (no flush): all registers hold; forwarding paths remain live.
- Load: capture all id_* values.
- Control bits are gated with id_valid, so an invalid ID slot loads as a bubble with ex_valid=0.
- Latency: one cycle ID→EX for all registered fields.
- ex_a/ex_b/ex_store_data are combinational from the registered values plus the forward muxes.
- Immediate:
  - id_ext_zero=1: {16'h0, imm}.
  - id_ext_zero=0: {{16{imm[15]}}, imm}.
  - Extension is computed before registering.
- Select decode (registered), ALUOp:
  - 00 → 0010
  - 01 → 0110
  - 11 → 0000
  - 10, by funct:
    - 100000 → 0010
    - 100010 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 100111 → 1100
    - 101010 → 0111
    - any other funct → 1111 with ex_illegal=1 (ALU then outputs 0).
- ex_illegal is 0 for ALUOp ≠ 10 and for bubbles.
- Operands:
  - ex_a = rsF.
  - ex_b = alu_src ? ext_imm : rtF.
  - ex_store_data = rtF.
  - rsF/rtF are the registered values, forwarded when enabled.

Optional Feature:
FORWARDING_EN.
- Defined: per operand, for registered source address s:
  - If fwd_exmem_we and fwd_exmem_rd==s and s≠0 → use fwd_exmem_val.
  - Else if fwd_memwb_we and fwd_memwb_rd==s and s≠0 → use fwd_memwb_val.
  - Else use the registered value.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
- Undefined: fwd_* ports present but ignored; rsF/rtF are the raw registered values.

Decomposition:
- Shared package holds:
  - ALU select constants: SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, SEL_NOR, SEL_BAD=4'b1111.
  - ALUOp constants.
  - R-type funct constants.
- The ALU reuses the select constants.
- One sub-module is natural: fwd_mux (one instance per source operand), holding the forwarding priority compare.

Test Plan:
- Reset mid-stream: load an R-type add, assert rst one cycle → ex_valid=0, ex_sel=0000, all control 0, ex_a=0.
- Decode:
  - ALUOp=10, funct=101010 → ex_sel=0111.
  - funct=000000 → ex_sel=1111, ex_illegal=1.
  - ALUOp=01 → 0110, ex_illegal=0.
- Immediate: imm=16'h8001, alu_src=1:
  - sign mode → ex_b=32'hFFFF8001.
  - zero mode → ex_b=32'h00008001.
- Stall/flush:
  - Stall 3 cycles with changing id_* → outputs constant.
  - flush and stall together → bubble (ex_valid=0, ex_reg_write=0).
- Forwarding (macro defined): registered rs=5, rs_val=1.
  - Both stages write r5 with 7 (EX/MEM) and 9 (MEM/WB) → ex_a=7.
  - Only MEM/WB matches → ex_a=9.
  - With rs=0 → ex_a=registered value.
- Macro undefined: same stimulus → ex_a=1 in every case.
